// File: rtl/adder_seq_pkg.sv
// Shared definitions for the sequenced adder controller.
//   state_e  : controller FSM states
//   beats_of : number of slice beats needed for one full-width add
//   id_width : bit width of a requester index (at least 1)
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned beats_of(input int unsigned width,
                                           input int unsigned slice);
    return width / slice;
  endfunction

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit adder with carry in/out; the one shared adder
// resource that adder_seq_ctrl time-multiplexes across beats.
//   a, b : slice operands
//   ci   : carry in
//   s    : slice sum
//   co   : carry out
module adder_slice #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);

  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};
  end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Sequencing controller: round-robin arbitration over NREQ operand ports,
// full-width add performed low slice first over WIDTH/SLICE beats through a
// single adder_slice, result returned on a valid/ready port tagged with id.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_ready : per-requester handshake (ready one-hot or zero)
//   req_a, req_b        : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : result handshake
//   rsp_sum, rsp_id     : (a+b) mod 2^WIDTH and issuing requester index
//   busy                : high whenever not IDLE
//   rsp_carry           : final-beat carry, present only with
//                         ADDER_SEQ_CARRY_EN defined
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8,
  parameter int unsigned NREQ  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*WIDTH-1:0]       req_a,
  input  logic [NREQ*WIDTH-1:0]       req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [WIDTH-1:0]            rsp_sum,
  output logic [id_width(NREQ)-1:0]   rsp_id,
  output logic                        busy
`ifdef ADDER_SEQ_CARRY_EN
  ,
  output logic                        rsp_carry
`endif
);

  localparam int unsigned BEATS = beats_of(WIDTH, SLICE);
  localparam int unsigned IDW   = id_width(NREQ);
  localparam int unsigned CW    = id_width(BEATS);

  state_e             state_q, state_n;
  logic [IDW-1:0]     ptr_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               carry_q;
  logic [CW-1:0]      beat_q;
  logic               last_beat;

  logic               grant_any;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     cand;
  logic [WIDTH-1:0]   sel_a, sel_b;

  logic [SLICE-1:0]   sl_a, sl_b, sl_s;
  logic               sl_co;

  // Round-robin search starting one past the last granted index.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = IDW'((32'(ptr_q) + off) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_any) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (beat_q == CW'(k)) begin
        sl_a = a_q[k*SLICE +: SLICE];
        sl_b = b_q[k*SLICE +: SLICE];
      end
    end
  end

  assign last_beat = (beat_q == CW'(BEATS - 1));

  adder_slice #(.SLICE(SLICE)) u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry_q),
    .s  (sl_s),
    .co (sl_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_n = RUN;
      RUN:     if (last_beat) state_n = DONE;
      DONE:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q     <= IDW'(NREQ - 1);
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      beat_q    <= '0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef ADDER_SEQ_CARRY_EN
      rsp_carry <= 1'b0;
`endif
    end else begin
      // Flag outputs are registered from the next state so they track state.
      rsp_valid <= (state_n == DONE);
      busy      <= (state_n != IDLE);
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            rsp_id  <= grant_id;
            ptr_q   <= grant_id;
            carry_q <= 1'b0;
            beat_q  <= '0;
          end
        end
        RUN: begin
          for (int unsigned k = 0; k < BEATS; k++) begin
            if (beat_q == CW'(k)) rsp_sum[k*SLICE +: SLICE] <= sl_s;
          end
          carry_q <= sl_co;
          beat_q  <= last_beat ? '0 : beat_q + CW'(1);
`ifdef ADDER_SEQ_CARRY_EN
          if (last_beat) rsp_carry <= sl_co;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/adder_seq_ctrl.md
# adder_seq_ctrl

Sequencing controller that time-multiplexes one narrow adder slice to produce full-width sums for several requesters. It arbitrates round-robin between NREQ operand ports, feeds the chosen operands through one SLICE-bit adder low slice first over WIDTH/SLICE beats, and carries between beats in a register. It returns the result on a valid/ready response port tagged with the requester id. It sits between operand producers and the shared adder datapath, and replaces replicated full-width adders where area matters more than throughput.

## Interface
- WIDTH, 32: operand and sum width.
- SLICE, 8: adder slice width; WIDTH must be a multiple of SLICE.
- NREQ, 2: number of requesters, minimum 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B, same packing.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_sum  output  WIDTH  (a + b) mod 2^WIDTH.
- rsp_id  output  max(1,$clog2(NREQ))  index of the requester that issued the operation.
- busy  output  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: if any req_valid is high, the arbiter grants one requester and drives its req_ready high combinationally. On the handshake edge, latch a, b and id, clear carry and beat counter, and go to RUN.
  - RUN: for beat k = 0..BEATS-1, compute slice k = a[k] + b[k] + carry. Write it into the sum register at [k*SLICE +: SLICE] and register the slice carry-out into carry. After beat BEATS-1, go to DONE.
  - DONE: rsp_valid high; rsp_sum and rsp_id stable. On rsp_valid && rsp_ready, go to IDLE.
- Round-robin arbitration:
  - A pointer holds the last granted index.
  - Search starts at pointer+1 and wraps modulo NREQ.
  - The pointer updates only on a completed request handshake.
  - After reset the pointer is NREQ-1, so requester 0 has first priority.
- req_ready is low in RUN and DONE. Requesters hold valid and operands until accepted; operands are sampled only at the handshake.
- Arithmetic wraps modulo 2^WIDTH. The final beat's carry-out is discarded unless the configuration macro below is defined.
- Reset values: state IDLE, req_ready 0, rsp_valid 0, rsp_sum 0, rsp_id 0, busy 0, carry 0, beat counter 0.
- Reset mid-operation (RUN or DONE) aborts the operation: no response, nothing retained.
- req_valid deasserting in IDLE before the handshake is legal. The grant is recomputed every cycle.

## Timing
- Handshake in cycle 0; RUN in cycles 1..BEATS; rsp_valid high from cycle BEATS+1. Defaults give a 5-cycle latency.
- rsp_ready high in the first DONE cycle gives IDLE the next cycle, and a new request can be accepted in that same IDLE cycle. Peak throughput is one operation per BEATS+2 cycles.
- rsp_ready held low: DONE is held indefinitely with outputs stable.
- req_ready is combinational from state and req_valid. All other outputs are registered.

## Configuration
- ADDER_SEQ_CARRY_EN:
  - Defined: adds output rsp_carry (1 bit), the carry-out of the final beat. It is valid with rsp_valid and resets to 0.
  - Undefined: the port is absent and the final carry is dropped.

## Structure
- Shared package adder_seq_pkg holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the BEATS = WIDTH/SLICE constant function;
  - the id-width helper function.
- Sub-module adder_slice: combinational SLICE-bit adder with carry-in and carry-out, instanced once. This is the shared resource.
- The arbiter, beat counter and FSM stay in adder_seq_ctrl.

## Test plan
- Single request: req0 a=0x0000_00FF, b=0x0000_0001 -> rsp_sum=0x0000_0100, rsp_id=0. rsp_valid exactly 5 cycles after the handshake; the carry chains from beat 0 to beat 1.
- Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0001 -> rsp_sum=0x0000_0000. rsp_carry=1 with ADDER_SEQ_CARRY_EN; no rsp_carry port without it.
- Contention: both requesters valid continuously after reset with distinct operands -> grants alternate 0,1,0,1. Each rsp_id matches its sum (0x1234_5678+0x1111_1111=0x2345_6789; 0x8000_0000+0x8000_0000=0x0000_0000).
- Backpressure: rsp_ready low for 10 cycles in DONE -> rsp_valid, rsp_sum and rsp_id stable, req_ready stays 0. On release, a new accept is possible the next cycle.
- Reset in RUN beat 2: rst_n low for 1 cycle -> all outputs return to reset values and no rsp_valid appears. The next request completes normally with requester 0 prioritised.
